// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;
    localparam int MDU_XLEN = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_e;
endpackage

// File: rtl/mdu_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on magnitudes.
module mdu_iter_core
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN-1:0] acc,
    output logic              last
);
    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0]   m;
    logic              div_q;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   hi, lo, diff;
    logic [XLEN:0]     r, sum;
    logic [2*XLEN-1:0] nxt;

    assign hi   = acc[2*XLEN-1:XLEN];
    assign lo   = acc[XLEN-1:0];
    assign last = (cnt == '0);

    // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
    // Multiply: hi accumulates, lo holds the remaining multiplier bits.
    always_comb begin
        r    = {hi, lo[XLEN-1]};
        diff = r[XLEN-1:0] - m;
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        nxt  = acc;
        if (div_q) begin
            if (r >= {1'b0, m}) nxt = {diff, lo[XLEN-2:0], 1'b1};
            else                nxt = {r[XLEN-1:0], lo[XLEN-2:0], 1'b0};
        end else begin
            nxt = {sum, lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            m     <= '0;
            div_q <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            m     <= is_div ? b : a;
            acc   <= {{XLEN{1'b0}}, (is_div ? a : b)};
            div_q <= is_div;
            cnt   <= CW'(XLEN - 1);
        end else if (step) begin
            acc <= nxt;
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU with HI/LO registers; FSM, sign fix-up and MTHI/MTLO.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs_i,
    input  logic [XLEN-1:0] rt_i,
    input  logic            kill_i,
    input  logic            mthi_i,
    input  logic            mtlo_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            dz_o
);
    mdu_state_e        state, nxt_state;
    mdu_op_e           op_q;
    logic [XLEN-1:0]   rs_q, rt_q, a_mag, b_mag, fix_hi, fix_lo;
    logic [2*XLEN-1:0] acc;
    logic              last, load, in_signed, op_div, q_signed, neg_q, neg_r, fix_dz;

    assign in_signed = ~op_i[0];
    assign a_mag     = (in_signed && rs_i[XLEN-1]) ? -rs_i : rs_i;
    assign b_mag     = (in_signed && rt_i[XLEN-1]) ? -rt_i : rt_i;
    assign load      = (state == S_IDLE) && start_i && !kill_i;
    assign busy_o    = (state != S_IDLE);

    mdu_iter_core #(.XLEN(XLEN)) u_core (
        .clk    (clk_i),
        .rst    (rst_i),
        .load   (load),
        .step   (state == S_CALC),
        .is_div (op_i[1]),
        .a      (a_mag),
        .b      (b_mag),
        .acc    (acc),
        .last   (last)
    );

    always_comb begin
        nxt_state = state;
        case (state)
            S_IDLE:  if (start_i && !kill_i) nxt_state = S_CALC;
            S_CALC:  if (kill_i) nxt_state = S_IDLE;
                     else if (last) nxt_state = S_FIX;
            S_FIX:   nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
    end

    assign op_div   = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
    assign q_signed = (op_q == MDU_MULT) || (op_q == MDU_DIV);
    assign neg_q    = q_signed && (rs_q[XLEN-1] ^ rt_q[XLEN-1]);
    assign neg_r    = q_signed && rs_q[XLEN-1];

    // Signed overflow (-2^(XLEN-1) / -1) falls out naturally: magnitude quotient is 2^(XLEN-1), no negation.
    always_comb begin
        fix_hi = acc[2*XLEN-1:XLEN];
        fix_lo = acc[XLEN-1:0];
        fix_dz = 1'b0;
        if (!op_div) begin
            if (neg_q) {fix_hi, fix_lo} = -acc;
        end else if (rt_q == '0) begin
            fix_lo = '1;
            fix_hi = rs_q;
            fix_dz = 1'b1;
        end else begin
            if (neg_q) fix_lo = -acc[XLEN-1:0];
            if (neg_r) fix_hi = -acc[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= S_IDLE;
            op_q   <= MDU_MULT;
            rs_q   <= '0;
            rt_q   <= '0;
            hi_o   <= '0;
            lo_o   <= '0;
            done_o <= 1'b0;
            dz_o   <= 1'b0;
        end else begin
            state  <= nxt_state;
            done_o <= 1'b0;
            dz_o   <= 1'b0;
            if (load) begin
                op_q <= mdu_op_e'(op_i);
                rs_q <= rs_i;
                rt_q <= rt_i;
            end
            if (state == S_FIX && !kill_i) begin
                hi_o   <= fix_hi;
                lo_o   <= fix_lo;
                done_o <= 1'b1;
                dz_o   <= fix_dz;
            end else if (state == S_IDLE && !start_i) begin
                if (mthi_i) hi_o <= wdata_i;
                if (mtlo_i) lo_o <= wdata_i;
            end
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, results, special cases, kill, MT moves, reset.
module tb_mult_div_unit;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] rs_i = '0, rt_i = '0, wdata_i = '0;
    logic        kill_i = 1'b0, mthi_i = 1'b0, mtlo_i = 1'b0;
    logic [31:0] hi_o, lo_o;
    logic        busy_o, done_o, dz_o;

    int total = 0;
    int bad = 0;
    int lat, nb, nd;

    mult_div_unit #(.XLEN(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
        .rs_i(rs_i), .rt_i(rt_i), .kill_i(kill_i), .mthi_i(mthi_i),
        .mtlo_i(mtlo_i), .wdata_i(wdata_i), .hi_o(hi_o), .lo_o(lo_o),
        .busy_o(busy_o), .done_o(done_o), .dz_o(dz_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue an op, then wait (bounded) for done_o; lat = cycle index of done after the start edge.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int l, output int busy_n);
        start_i = 1'b1; op_i = op; rs_i = a; rt_i = b;
        tick();
        start_i = 1'b0;
        l = 1; busy_n = 0;
        while (!done_o && l < 100) begin
            if (busy_o) busy_n++;
            tick();
            l++;
        end
    endtask

    initial begin
        tick(); tick();
        rst_i = 1'b0;
        chk("rst_hi", hi_o, 0);
        chk("rst_lo", lo_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_dz", dz_o, 0);

        // 1. MULTU max*max
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, nb);
        chk("multu_lat", lat, 34);
        chk("multu_busy_cycles", nb, 33);
        chk("multu_busy_at_done", busy_o, 0);
        chk("multu_hi", hi_o, 32'hFFFF_FFFE);
        chk("multu_lo", lo_o, 32'h0000_0001);
        tick();
        chk("done_pulse_one_cycle", done_o, 0);

        // 2. signed mult/div
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, lat, nb);
        chk("mult_hi", hi_o, 32'hFFFF_FFFF);
        chk("mult_lo", lo_o, 32'hFFFF_FFEB);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, nb);
        chk("div_lat", lat, 34);
        chk("div_lo", lo_o, 32'hFFFF_FFFD);
        chk("div_hi", hi_o, 32'hFFFF_FFFF);
        chk("div_dz", dz_o, 0);

        // 3. divide by zero, signed overflow
        run_op(2'b11, 32'd100, 32'd0, lat, nb);
        chk("dz_lat", lat, 34);
        chk("dz_lo", lo_o, 32'hFFFF_FFFF);
        chk("dz_hi", hi_o, 32'd100);
        chk("dz_flag", dz_o, 1);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, nb);
        chk("ovf_lo", lo_o, 32'h8000_0000);
        chk("ovf_hi", hi_o, 32'h0);
        chk("ovf_dz", dz_o, 0);

        // 4. kill at cycle 10, then restart at cycle 11
        start_i = 1'b1; op_i = 2'b11; rs_i = 32'd9; rt_i = 32'd2;
        tick();
        start_i = 1'b0;
        nd = 0;
        for (int c = 1; c < 10; c++) begin
            if (done_o) nd++;
            tick();
        end
        chk("kill_busy_before", busy_o, 1);
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
        chk("kill_idle", busy_o, 0);
        chk("kill_no_done", nd + int'(done_o), 0);
        chk("kill_hi_kept", hi_o, 32'h0);
        chk("kill_lo_kept", lo_o, 32'h8000_0000);
        run_op(2'b11, 32'd9, 32'd2, lat, nb);
        chk("after_kill_lat", lat, 34);
        chk("after_kill_lo", lo_o, 32'd4);
        chk("after_kill_hi", hi_o, 32'd1);

        // kill together with start in IDLE: nothing starts
        tick();
        start_i = 1'b1; kill_i = 1'b1; op_i = 2'b01; rs_i = 32'd3; rt_i = 32'd3;
        tick();
        start_i = 1'b0; kill_i = 1'b0;
        chk("kill_start_idle", busy_o, 0);

        // 5. MT moves
        mthi_i = 1'b1; wdata_i = 32'h1234;
        tick();
        mthi_i = 1'b0;
        chk("mthi", hi_o, 32'h1234);
        chk("mthi_lo_kept", lo_o, 32'd4);
        mthi_i = 1'b1; mtlo_i = 1'b1; wdata_i = 32'hABCD;
        tick();
        mthi_i = 1'b0; mtlo_i = 1'b0;
        chk("mt_both_hi", hi_o, 32'hABCD);
        chk("mt_both_lo", lo_o, 32'hABCD);

        start_i = 1'b1; op_i = 2'b01; rs_i = 32'd3; rt_i = 32'd5;
        tick();
        start_i = 1'b0;
        mtlo_i = 1'b1; wdata_i = 32'hDEAD;
        tick(); tick();
        mtlo_i = 1'b0;
        chk("mtlo_busy_dropped", lo_o, 32'hABCD);
        start_i = 1'b1; op_i = 2'b01; rs_i = 32'd7; rt_i = 32'd7;
        tick();
        start_i = 1'b0;
        nd = 0;
        for (int c = 0; c < 80; c++) begin
            if (done_o) begin
                nd++;
                if (nd == 1) chk("busy_start_ignored_lo", lo_o, 32'd15);
            end
            tick();
        end
        chk("single_done", nd, 1);

        // start with move in same cycle: move dropped
        start_i = 1'b1; mthi_i = 1'b1; wdata_i = 32'h5555; op_i = 2'b01; rs_i = 32'd2; rt_i = 32'd2;
        tick();
        start_i = 1'b0; mthi_i = 1'b0;
        chk("start_beats_mthi", hi_o, 32'h0);
        for (int c = 0; c < 40; c++) tick();

        // 6. reset mid-op, then back-to-back ops
        start_i = 1'b1; op_i = 2'b00; rs_i = 32'd6; rt_i = 32'd6;
        tick();
        start_i = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_hi", hi_o, 0);
        chk("rst_mid_lo", lo_o, 0);
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            if (done_o) nd++;
            tick();
        end
        chk("rst_mid_no_done", nd, 0);

        run_op(2'b01, 32'd10, 32'd20, lat, nb);
        chk("b2b_1_lat", lat, 34);
        chk("b2b_1_lo", lo_o, 32'd200);
        run_op(2'b10, 32'd50, 32'hFFFF_FFF9, lat, nb);
        chk("b2b_2_lat", lat, 34);
        chk("b2b_2_lo", lo_o, 32'hFFFF_FFF9);
        chk("b2b_2_hi", hi_o, 32'd1);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, lat, nb);
        chk("b2b_3_lat", lat, 34);
        chk("b2b_3_hi", hi_o, 32'h4000_0000);
        chk("b2b_3_lo", lo_o, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
